// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write path.
package regfile_pkg;

    localparam int AW    = 6;
    localparam int NREGS = 2 ** AW;
    localparam int DW    = 64;

    // Decode a register address into a one-hot write-enable vector.
    function automatic logic [NREGS-1:0] onehot64(input logic [AW-1:0] addr);
        logic [NREGS-1:0] one;
        one = {{(NREGS - 1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requesting index at or after ptr
// (wrapping modulo NREQ) and advances ptr past the winner.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] sel;
    int            idx;

    // Scan from ptr upward with wraparound; the first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = idx[IW-1:0];
            if (en && !grant_any && req[sel]) begin
                grant_any  = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

    // Pointer moves to the index just after the winner; otherwise it holds.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            if (grant_idx == IW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Pointer register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port among NREQ requesters.
// One grant per cycle, round-robin; the winning write is registered and
// presented for one non-stalled cycle with a one-hot write-enable vector.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DW           = 64,
    parameter int AW           = 6,
    parameter int ZERO_PROTECT = 1,
    localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               wr_stall,
    output logic               wr_valid,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [63:0]        wr_en,
    output logic [IW-1:0]      grant_id
);

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    logic            arb_en;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;

    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [63:0]     sel_en;

    logic            wr_valid_q, wr_valid_d;
    logic [AW-1:0]   wr_addr_q,  wr_addr_d;
    logic [DW-1:0]   wr_data_q,  wr_data_d;
    logic [63:0]     wr_en_q,    wr_en_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;

    // Unpack the flat request buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // No grants while in reset or while the register file is stalled.
    assign arb_en    = !rst && !wr_stall;
    assign req_ready = grant;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];

    // Address decode; address 0 optionally produces no enable at all.
    always_comb begin
        sel_en = regfile_pkg::onehot64(sel_addr);
        if ((ZERO_PROTECT != 0) && (sel_addr == '0)) begin
            sel_en = '0;
        end
    end

    // Output-stage next state: load on transfer, retire otherwise, freeze on stall.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = wr_en_q;
        grant_id_d = grant_id_q;
        if (!wr_stall) begin
            if (grant_any) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = sel_addr;
                wr_data_d  = sel_data;
                wr_en_d    = sel_en;
                grant_id_d = grant_idx;
            end else begin
                wr_valid_d = 1'b0;
                wr_en_d    = '0;
            end
        end
    end

    // Output registers; reset discards any presented write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= '0;
            grant_id_q <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Two instances share stimulus:
// one with zero-address protection, one without.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int AW   = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               wr_stall;

    logic [NREQ-1:0]    req_ready,  req_ready0;
    logic               wr_valid,   wr_valid0;
    logic [AW-1:0]      wr_addr,    wr_addr0;
    logic [DW-1:0]      wr_data,    wr_data0;
    logic [63:0]        wr_en,      wr_en0;
    logic [1:0]         grant_id,   grant_id0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .ZERO_PROTECT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_stall(wr_stall),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .grant_id(grant_id)
    );

    regfile_write_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .ZERO_PROTECT(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready0), .wr_stall(wr_stall),
        .wr_valid(wr_valid0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .wr_en(wr_en0), .grant_id(grant_id0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        wr_stall  = 1'b0;
        req_valid = 4'hF;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, AW'(i + 1), 64'hA0 + 64'(i));
        end

        // Reset held two cycles with everyone requesting.
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(wr_valid), 64'h0);
        chk("rst_en", wr_en, 64'h0);
        step();
        chk("rst1_ready", 64'(req_ready), 64'h0);
        step();
        rst = 1'b0;
        #1;
        $display("reset released");
        chk("post_rst_valid", 64'(wr_valid), 64'h0);
        chk("post_rst_en", wr_en, 64'h0);
        chk("post_rst_addr", 64'(wr_addr), 64'h0);
        chk("post_rst_gid", 64'(grant_id), 64'h0);
        chk("post_rst_ready", 64'(req_ready), 64'h1);

        // Fairness: all four continuously valid, addresses 1..4.
        for (int n = 0; n < 6; n++) begin
            step();
            $display("fair grant %0d: gid=%0d wr_en=%h", n, grant_id, wr_en);
            chk("fair_valid", 64'(wr_valid), 64'h1);
            chk("fair_gid", 64'(grant_id), 64'(n % 4));
            chk("fair_en", wr_en, 64'h2 << (n % 4));
            chk("fair_data", wr_data, 64'hA0 + 64'(n % 4));
        end

        // Mid-stream reset with ptr at 2.
        chk("ptr2_ready", 64'(req_ready), 64'h4);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'h0);
        step();
        $display("mid-stream reset applied");
        chk("midrst_valid", 64'(wr_valid), 64'h0);
        chk("midrst_en", wr_en, 64'h0);
        rst = 1'b0;
        #1;
        chk("after_midrst_ready", 64'(req_ready), 64'h1);
        step();
        chk("after_midrst_gid", 64'(grant_id), 64'h0);
        chk("after_midrst_valid", 64'(wr_valid), 64'h1);
        req_valid = 4'h0;
        step();
        chk("idle_valid", 64'(wr_valid), 64'h0);
        chk("idle_en", wr_en, 64'h0);
        chk("idle_gid_hold", 64'(grant_id), 64'h0);

        // Single write from requester 2 (ptr now 1).
        set_req(2, 6'd5, 64'hDEAD);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = 4'h0;
        $display("single write: addr=%0d data=%h gid=%0d", wr_addr, wr_data, grant_id);
        chk("single_valid", 64'(wr_valid), 64'h1);
        chk("single_addr", 64'(wr_addr), 64'd5);
        chk("single_en", wr_en, 64'h20);
        chk("single_data", wr_data, 64'hDEAD);
        chk("single_gid", 64'(grant_id), 64'h2);
        step();
        chk("single_retire", 64'(wr_valid), 64'h0);
        chk("single_addr_hold", 64'(wr_addr), 64'd5);

        // Stall: requester 3 writes addr 7, then stall 3 cycles.
        set_req(3, 6'd7, 64'h77);
        set_req(0, 6'd1, 64'h11);
        set_req(1, 6'd9, 64'h99);
        req_valid = 4'b1000;
        #1;
        chk("stall_pre_ready", 64'(req_ready), 64'h8);
        step();
        req_valid = 4'b0111;
        wr_stall  = 1'b1;
        chk("stall_load_en", wr_en, 64'h80);
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stall_ready", 64'(req_ready), 64'h0);
            step();
            $display("stall cycle %0d: valid=%0d wr_en=%h", n, wr_valid, wr_en);
            chk("stall_valid", 64'(wr_valid), 64'h1);
            chk("stall_en", wr_en, 64'h80);
            chk("stall_addr", 64'(wr_addr), 64'd7);
            chk("stall_gid", 64'(grant_id), 64'h3);
        end
        wr_stall = 1'b0;
        #1;
        chk("release_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 4'h0;
        chk("release_gid", 64'(grant_id), 64'h0);
        chk("release_en", wr_en, 64'h2);
        chk("release_data", wr_data, 64'h11);
        step();

        // Zero address from requester 1 (ptr now 1).
        set_req(1, 6'd0, 64'h5A5A);
        req_valid = 4'b0010;
        #1;
        chk("zero_ready", 64'(req_ready), 64'h2);
        chk("zero_ready_np", 64'(req_ready0), 64'h2);
        step();
        req_valid = 4'h0;
        $display("zero addr: prot wr_en=%h noprot wr_en=%h", wr_en, wr_en0);
        chk("zero_valid", 64'(wr_valid), 64'h1);
        chk("zero_en_prot", wr_en, 64'h0);
        chk("zero_data", wr_data, 64'h5A5A);
        chk("zero_valid_np", 64'(wr_valid0), 64'h1);
        chk("zero_en_np", wr_en0, 64'h1);
        step();
        chk("zero_retire", 64'(wr_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 64-entry register file among NREQ requesters (e.g. ALU writeback, load return, link-register write, debug port). Arbitrates round-robin, one write per cycle, with a valid/ready handshake per requester. Registers the winning address and data, and drives a registered one-hot 64-bit write-enable vector produced by 6-to-64 decoding of the winning address. Sits between the execute/memory writeback sources and the register file.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 64: write data width
- AW, 6: address width; register count NREGS = 2**AW = 64, fixed
- ZERO_PROTECT, 1: 1 = writes to address 0 are accepted but produce all-zero wr_en
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a pending write
- req_addr  in  NREQ*AW  packed; requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed; requester i at [i*DW +: DW]
- req_ready  out  NREQ  combinational grant; at most one bit high
- wr_stall  in  1  register file cannot take a write this cycle
- wr_valid  out  1  registered write strobe
- wr_addr  out  AW  registered write address
- wr_data  out  DW  registered write data
- wr_en  out  64  registered one-hot decode of wr_addr, gated by wr_valid
- grant_id  out  clog2(NREQ)  requester index of the current output write

## Operation
- Handshake: a transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both high. The requester holds valid, addr, and data stable until then, and must not drop valid before ready.
- req_ready[i] = !rst && !wr_stall && req_valid[i] && (i is the first valid index at or after ptr, modulo NREQ).
- Round-robin pointer ptr: after a grant to i, ptr <= (i+1) mod NREQ. No grant leaves ptr unchanged.
- Output stage, on each edge with !wr_stall:
  - Transfer: wr_valid <= 1; wr_addr and wr_data take the granted values; grant_id <= i; wr_en <= onehot(addr).
  - No transfer: wr_valid <= 0 and wr_en <= 0. wr_addr, wr_data, and grant_id hold.
- Stall: wr_stall high freezes every output register and ptr. All req_ready are 0.
- Zero address: with ZERO_PROTECT=1, addr 0 is still handshaken and wr_valid=1, but wr_en=0. With ZERO_PROTECT=0, wr_en=64'h1.
- Collisions between requesters writing the same address are not detected. Writes are serialized in grant order.

## Timing
- Reset values: wr_valid=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, ptr=0. req_ready=0 while rst is high.
- Latency: exactly 1 cycle from the handshake edge to wr_valid/wr_en visible (0 cycles of stall). Each write is presented for exactly one non-stalled cycle.
- Throughput: 1 write per cycle when wr_stall=0.
- Stall asserted while wr_valid=1: the same write stays presented until the first cycle with wr_stall=0. It is retired at that edge, and a new grant may load in the same edge.
- Reset mid-operation: the pending output write is discarded (wr_valid=0 next cycle) and ptr returns to 0. Requesters keep valid asserted and are regranted after reset.
- Simultaneous requests: exactly one grant per cycle, by the ptr rule. No requester waits more than NREQ-1 grants.

## Structure
- Package regfile_pkg: AW, NREGS, DW, and a function onehot64(addr) returning a 64-bit vector with bit addr set.
- Sub-module rr_arbiter, parameterized by NREQ: inputs are req, ptr, and enable; outputs are a one-hot grant and a grant index. It owns the ptr register and its update.
- Top level holds the output registers, the decode, and zero-protect gating.

## Test plan
- Reset: rst high 2 cycles with all req_valid=1 -> req_ready=0, wr_valid=0, and wr_en=0 during reset and on the first cycle after; the first grant goes to requester 0.
- Single write: req_valid[2]=1, addr=5, data=64'hDEAD -> req_ready[2]=1 the same cycle. Next cycle: wr_valid=1, wr_addr=5, wr_en=64'h20, wr_data=64'hDEAD, grant_id=2. The following cycle: wr_valid=0.
- Fairness: all 4 requesters continuously valid with addresses 1..4 -> grant_id sequence 0,1,2,3,0,1 and wr_en sequence 2,4,8,16,2,4.
- Stall: wr_stall=1 for 3 cycles while wr_valid=1, addr=7 -> outputs are frozen, wr_en=64'h80 is held, and all req_ready=0. After release, the next grant is the requester after the stalled one.
- Zero address: addr 0 with ZERO_PROTECT=1 -> handshake completes, wr_valid=1, wr_en=0. With ZERO_PROTECT=0 -> wr_en=64'h1.
- Mid-stream reset: rst pulsed one cycle during continuous grants, ptr=2 -> wr_valid=0 the next cycle, and the first post-reset grant goes to requester 0.
